cdb_arbiter: RTL and testbench

Arbitrates result writeback from the functional units (ALU, load/store buffer, branch unit) onto the single common data bus (CDB) that feeds the reorder buffer and the reservation stations. Each cycle it grants at most one valid requester, latches that requester's RoB tag and result into a registered broadcast stage, and raises the winner's ready. It sits between the execution units and the RoB, and obeys the pipeline-wide flush.

---
 rtl/cdb_arbiter.sv | 77 +++++++
 tb/tb_cdb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one functional unit per cycle onto a registered CDB stage.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module cdb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int RoB_WIDTH  = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*RoB_WIDTH-1:0]  req_rob_id,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          cdb_valid,
    output logic [RoB_WIDTH-1:0]          cdb_rob_id,
    output logic [DATA_WIDTH-1:0]         cdb_value,
    output logic [1:0]                    cdb_src
);

    logic [1:0] last_grant;
    logic [1:0] win;
    logic       found;
    logic       grant_en;

`ifdef CDB_ROUND_ROBIN_EN
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                win   = 2'(idx);
                found = 1'b1;
            end
        end
    end
`else
    // Scan from the top so the lowest valid index is the last one written.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win   = 2'(i);
                found = 1'b1;
            end
        end
    end
`endif

    assign grant_en  = rdy_in && !rst_in && !flush_in && found;
    assign req_ready = grant_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win)
                                : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= '0;
            last_grant <= 2'(NUM_REQ - 1);
        end else if (rdy_in) begin
            cdb_valid <= found;
            if (found) begin
                cdb_rob_id <= req_rob_id[win*RoB_WIDTH +: RoB_WIDTH];
                cdb_value  <= req_value[win*DATA_WIDTH +: DATA_WIDTH];
                cdb_src    <= win;
                last_grant <= win;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector table plus hand sequences for cdb_arbiter.
// Expectations adapt to CDB_ROUND_ROBIN_EN where the two modes differ.
module tb_cdb_arbiter;

    localparam int NR = 3;
    localparam int RW = 3;
    localparam int DW = 32;

    logic              clk_in = 1'b0;
    logic              rst_in, rdy_in, flush_in;
    logic [NR-1:0]     req_valid;
    logic [NR*RW-1:0]  req_rob_id;
    logic [NR*DW-1:0]  req_value;
    logic [NR-1:0]     req_ready;
    logic              cdb_valid;
    logic [RW-1:0]     cdb_rob_id;
    logic [DW-1:0]     cdb_value;
    logic [1:0]        cdb_src;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.NUM_REQ(NR), .RoB_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .req_valid  (req_valid),
        .req_rob_id (req_rob_id),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       flush;
        logic       rdy;
        logic [2:0] valid;
        logic [8:0] ids;
        logic [2:0] exp_ready;
        logic       exp_cv;
        logic [2:0] exp_tag;
        logic [1:0] exp_src;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pay(input int i, input logic [2:0] t);
        return 32'hC0DE_0000 | (32'(i) << 8) | 32'(t);
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic f,
                                input logic y, input logic [2:0] v,
                                input logic [8:0] ids, input logic [2:0] er,
                                input logic cv, input logic [2:0] tg,
                                input logic [1:0] src, input logic [31:0] val);
        vec_t x;
        x.name = nm; x.rst = r; x.flush = f; x.rdy = y; x.valid = v;
        x.ids = ids; x.exp_ready = er; x.exp_cv = cv; x.exp_tag = tg;
        x.exp_src = src; x.exp_val = val;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic y,
                         input logic [2:0] v, input logic [8:0] ids);
        rst_in = r; flush_in = f; rdy_in = y;
        req_valid = v; req_rob_id = ids;
        for (int i = 0; i < NR; i++)
            req_value[i*DW +: DW] = pay(i, ids[i*RW +: RW]);
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 9'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 3'b000, 9'd0);
    endtask

    initial begin
        int cnt6, nbc, n0, n1;
        logic [2:0] exp_r;
        logic [1:0] exp_s;

        drive(1'b1, 1'b0, 1'b1, 3'b111, 9'd0);

        // ids packed as {id2, id1, id0}
        vecs.push_back(mk("rst_a", 1,0,1, 3'b111, {3'd1,3'd2,3'd3}, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk("rst_b", 1,0,1, 3'b111, {3'd1,3'd2,3'd3}, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk("idle", 0,0,1, 3'b000, 9'd0, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk("single_alu", 0,0,1, 3'b001, {3'd0,3'd0,3'd3}, 3'b001, 1, 3, 0, pay(0,3)));
        vecs.push_back(mk("single_br", 0,0,1, 3'b100, {3'd3,3'd0,3'd0}, 3'b100, 1, 3, 2, pay(2,3)));
        vecs.push_back(mk("stall1", 0,0,0, 3'b100, {3'd5,3'd0,3'd0}, 3'b000, 1, 3, 2, pay(2,3)));
        vecs.push_back(mk("stall2", 0,0,0, 3'b100, {3'd5,3'd0,3'd0}, 3'b000, 1, 3, 2, pay(2,3)));
        vecs.push_back(mk("stall3", 0,0,0, 3'b100, {3'd5,3'd0,3'd0}, 3'b000, 1, 3, 2, pay(2,3)));
        vecs.push_back(mk("resume", 0,0,1, 3'b100, {3'd5,3'd0,3'd0}, 3'b100, 1, 5, 2, pay(2,5)));
        vecs.push_back(mk("flush", 0,1,1, 3'b101, {3'd2,3'd0,3'd1}, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk("post_flush", 0,0,1, 3'b101, {3'd2,3'd0,3'd1}, 3'b001, 1, 1, 0, pay(0,1)));
        vecs.push_back(mk("idle_hold", 0,0,1, 3'b000, 9'd0, 3'b000, 0, 1, 0, pay(0,1)));
        vecs.push_back(mk("flush_rdy0", 0,1,0, 3'b010, {3'd0,3'd4,3'd0}, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk("lsb", 0,0,1, 3'b010, {3'd0,3'd4,3'd0}, 3'b010, 1, 4, 1, pay(1,4)));
`ifdef CDB_ROUND_ROBIN_EN
        vecs.push_back(mk("pick", 0,0,1, 3'b101, {3'd7,3'd0,3'd6}, 3'b100, 1, 7, 2, pay(2,7)));
`else
        vecs.push_back(mk("pick", 0,0,1, 3'b101, {3'd7,3'd0,3'd6}, 3'b001, 1, 6, 0, pay(0,6)));
`endif

        #1;
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].flush, vecs[k].rdy, vecs[k].valid, vecs[k].ids);
            #1;
            chk({vecs[k].name, ".ready"}, 32'(req_ready), 32'(vecs[k].exp_ready));
            tick();
            chk({vecs[k].name, ".cv"}, 32'(cdb_valid), 32'(vecs[k].exp_cv));
            chk({vecs[k].name, ".tag"}, 32'(cdb_rob_id), 32'(vecs[k].exp_tag));
            chk({vecs[k].name, ".src"}, 32'(cdb_src), 32'(vecs[k].exp_src));
            chk({vecs[k].name, ".val"}, cdb_value, vecs[k].exp_val);
            if (vecs[k].name == "flush")
                chk("flush.last_grant", 32'(dut.last_grant), 32'd2);
        end

        // Single LSB request with a distinctive payload.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'b010, {3'd0,3'd5,3'd0});
        req_value[DW +: DW] = 32'hDEAD_BEEF;
        #1;
        chk("deadbeef.ready", 32'(req_ready), 32'b010);
        tick();
        chk("deadbeef.cv", 32'(cdb_valid), 32'd1);
        chk("deadbeef.tag", 32'(cdb_rob_id), 32'd5);
        chk("deadbeef.val", cdb_value, 32'hDEAD_BEEF);
        chk("deadbeef.src", 32'(cdb_src), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 9'd0);
        tick();
        chk("deadbeef.drop", 32'(cdb_valid), 32'd0);

        // All three requesters valid for six cycles.
        do_reset();
        for (int c = 0; c < 6; c++) begin
`ifdef CDB_ROUND_ROBIN_EN
            exp_s = 2'(c % 3);
`else
            exp_s = 2'd0;
`endif
            exp_r = 3'b001 << exp_s;
            drive(1'b0, 1'b0, 1'b1, 3'b111, {3'd2,3'd1,3'd0});
            #1;
            chk($sformatf("contend%0d.ready", c), 32'(req_ready), 32'(exp_r));
            tick();
            chk($sformatf("contend%0d.src", c), 32'(cdb_src), 32'(exp_s));
            chk($sformatf("contend%0d.tag", c), 32'(cdb_rob_id), 32'(exp_s));
        end

        // Requester 1 waits behind two ALU entries; tag 6 must go out once.
        do_reset();
        n0 = 2; n1 = 1; cnt6 = 0; nbc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, 1'b1, {1'b0, n1 > 0, n0 > 0},
                  {3'd0, 3'd6, (n0 == 2) ? 3'd1 : 3'd2});
            #1;
            if (req_valid[0] && req_ready[0]) n0--;
            if (req_valid[1] && req_ready[1]) n1--;
            tick();
            if (cdb_valid) begin
                nbc++;
                if (cdb_src == 2'd1 && cdb_rob_id == 3'd6) cnt6++;
            end
        end
        chk("stable.tag6_once", 32'(cnt6), 32'd1);
        chk("stable.broadcasts", 32'(nbc), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
